// File: rtl/car_exit_gate_if.sv
// Exit-gate signal bundle: sensor and entry inputs, and gate/occupancy status.
// The entry side and the departure output are single-cycle pulses, not
// handshakes. An entry_pulse held high for one cycle admits one car.
// exit_pulse is high for exactly one cycle per departure. Neither side can
// stall the other.
interface car_exit_gate_if #(
    parameter int CNT_BITS = 6
);
    logic                clear;
    logic                entry_pulse;
    logic                exit_sensor;
    logic                gate_open;
    logic                exit_pulse;
    logic [CNT_BITS-1:0] occupancy;
    logic                lot_full;
    logic                lot_empty;
    logic                err_overflow;
    logic                err_underflow;

    // Environment side: drives the sensor, clear and entry pulses.
    modport master (
        output clear, entry_pulse, exit_sensor,
        input  gate_open, exit_pulse, occupancy, lot_full, lot_empty,
               err_overflow, err_underflow
    );

    // Controller side.
    modport slave (
        input  clear, entry_pulse, exit_sensor,
        output gate_open, exit_pulse, occupancy, lot_full, lot_empty,
               err_overflow, err_underflow
    );
endinterface

// File: rtl/car_exit_gate.sv
// Exit gate controller: debounces the exit loop, sequences the gate, and
// owns the lot occupancy count with full/empty status and sticky errors.
module car_exit_gate #(
    parameter int MAX_CARS = 50,
    parameter int CNT_BITS = 6,
    parameter int DEBOUNCE = 4
) (
    input  logic           clk_i,
    input  logic           rst_i,
    car_exit_gate_if.slave bus,
    output logic [1:0]     dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DETECT = 2'd1,
        OPEN   = 2'd2,
        DEPART = 2'd3
    } state_e;

    localparam logic [4:0]          DB  = 5'(DEBOUNCE);
    localparam logic [CNT_BITS-1:0] MAX = CNT_BITS'(MAX_CARS);
    localparam logic [CNT_BITS-1:0] ONE = CNT_BITS'(1);

    state_e              state_q, state_d;
    logic [3:0]          dcnt_q, dcnt_d;
    logic [4:0]          dcnt_inc;
    logic                depart_evt;
    logic                gate_q;
    logic                pulse_q;
    logic [CNT_BITS-1:0] occ_q, occ_d;
    logic                ovf_q, ovf_d;
    logic                unf_q, unf_d;

    // Next state of the debounce FSM. A departure event is the edge that
    // leaves DEPART (or OPEN when DEBOUNCE is 1) for IDLE.
    always_comb begin
        state_d    = state_q;
        dcnt_d     = dcnt_q;
        depart_evt = 1'b0;
        dcnt_inc   = {1'b0, dcnt_q} + 5'd1;
        case (state_q)
            IDLE: begin
                if (bus.exit_sensor) begin
                    if (DB == 5'd1) begin
                        state_d = OPEN;
                        dcnt_d  = 4'd0;
                    end else begin
                        state_d = DETECT;
                        dcnt_d  = 4'd1;
                    end
                end
            end
            DETECT: begin
                if (bus.exit_sensor) begin
                    if (dcnt_inc == DB) begin
                        state_d = OPEN;
                        dcnt_d  = 4'd0;
                    end else begin
                        dcnt_d = dcnt_inc[3:0];
                    end
                end else begin
                    state_d = IDLE;
                    dcnt_d  = 4'd0;
                end
            end
            OPEN: begin
                if (!bus.exit_sensor) begin
                    if (DB == 5'd1) begin
                        state_d    = IDLE;
                        dcnt_d     = 4'd0;
                        depart_evt = 1'b1;
                    end else begin
                        state_d = DEPART;
                        dcnt_d  = 4'd1;
                    end
                end
            end
            DEPART: begin
                if (!bus.exit_sensor) begin
                    if (dcnt_inc == DB) begin
                        state_d    = IDLE;
                        dcnt_d     = 4'd0;
                        depart_evt = 1'b1;
                    end else begin
                        dcnt_d = dcnt_inc[3:0];
                    end
                end else begin
                    state_d = OPEN;
                    dcnt_d  = 4'd0;
                end
            end
            default: begin
                state_d = IDLE;
                dcnt_d  = 4'd0;
            end
        endcase
    end

    // FSM state, debounce count, and the registered gate and pulse outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            dcnt_q  <= 4'd0;
            gate_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
            gate_q  <= (state_d == OPEN) || (state_d == DEPART);
            pulse_q <= depart_evt;
        end
    end

    // Occupancy next value: clear wins, a simultaneous entry and departure
    // cancel, otherwise saturate at either end and flag the attempt.
    always_comb begin
        occ_d = occ_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (bus.clear) begin
            occ_d = '0;
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end else if (bus.entry_pulse && depart_evt) begin
            occ_d = occ_q;
        end else if (bus.entry_pulse) begin
            if (occ_q < MAX) occ_d = occ_q + ONE;
            else             ovf_d = 1'b1;
        end else if (depart_evt) begin
            if (occ_q != '0) occ_d = occ_q - ONE;
            else             unf_d = 1'b1;
        end
    end

    // Occupancy register and sticky error flags.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            occ_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            occ_q <= occ_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign bus.gate_open     = gate_q;
    assign bus.exit_pulse    = pulse_q;
    assign bus.occupancy     = occ_q;
    assign bus.lot_full      = (occ_q == MAX);
    assign bus.lot_empty     = (occ_q == '0);
    assign bus.err_overflow  = ovf_q;
    assign bus.err_underflow = unf_q;
    assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_car_exit_gate.sv
// Bench for car_exit_gate: directed scenarios plus random sensor/entry
// traffic, compared cycle by cycle against a behavioural model.
module tb_car_exit_gate;
    localparam int MAX_CARS = 50;
    localparam int CNT_BITS = 6;
    localparam int DEBOUNCE = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    car_exit_gate_if #(.CNT_BITS(CNT_BITS)) bus ();
    logic [1:0] dbg_state;

    car_exit_gate #(
        .MAX_CARS(MAX_CARS),
        .CNT_BITS(CNT_BITS),
        .DEBOUNCE(DEBOUNCE)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .bus        (bus),
        .dbg_state_o(dbg_state)
    );

    // ---------------- reference model ----------------
    // The gate is either down or up; m_run counts consecutive samples that
    // disagree with the current gate position.
    bit m_open;
    int m_run;
    int m_occ;
    bit m_ovf;
    bit m_unf;
    bit m_pulse;
    logic [CNT_BITS-1:0] exp_q[$];   // expected occupancy seen with each exit_pulse

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_open  = 1'b0;
        m_run   = 0;
        m_occ   = 0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
        m_pulse = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_edge(input bit s, input bit e, input bit c);
        bit dep;
        dep = 1'b0;
        if ((s && !m_open) || (!s && m_open)) m_run++;
        else                                  m_run = 0;
        if (m_run == DEBOUNCE) begin
            dep    = m_open;
            m_open = !m_open;
            m_run  = 0;
        end
        m_pulse = dep;
        if (c) begin
            m_occ = 0;
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else if (e && dep) begin
            m_occ = m_occ;
        end else if (e) begin
            if (m_occ < MAX_CARS) m_occ++;
            else                  m_ovf = 1'b1;
        end else if (dep) begin
            if (m_occ > 0) m_occ--;
            else           m_unf = 1'b1;
        end
        if (dep) exp_q.push_back(CNT_BITS'(m_occ));
    endtask

    task automatic compare_outputs();
        check("gate_open",     int'(bus.gate_open),     int'(m_open));
        check("exit_pulse",    int'(bus.exit_pulse),    int'(m_pulse));
        check("occupancy",     int'(bus.occupancy),     m_occ);
        check("lot_full",      int'(bus.lot_full),      int'(m_occ == MAX_CARS));
        check("lot_empty",     int'(bus.lot_empty),     int'(m_occ == 0));
        check("err_overflow",  int'(bus.err_overflow),  int'(m_ovf));
        check("err_underflow", int'(bus.err_underflow), int'(m_unf));
        if (bus.exit_pulse) begin
            if (exp_q.size() > 0) check("depart_occ", int'(bus.occupancy), int'(exp_q.pop_front()));
            else                  check("spurious_pulse", int'(bus.exit_pulse), 0);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input bit s, input bit e, input bit c);
        @(negedge clk);
        bus.exit_sensor = s;
        bus.entry_pulse = e;
        bus.clear       = c;
        model_edge(s, e, c);
        @(posedge clk);
        #1;
        compare_outputs();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.exit_sensor = 1'b0;
        bus.entry_pulse = 1'b0;
        bus.clear       = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One full car: DEBOUNCE high samples, DEBOUNCE low samples, with an
    // optional entry pulse on the departure edge.
    task automatic car_pass(input bit e_on_depart);
        repeat (DEBOUNCE) step(1'b1, 1'b0, 1'b0);
        repeat (DEBOUNCE - 1) step(1'b0, 1'b0, 1'b0);
        step(1'b0, e_on_depart, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus.exit_sensor = 1'b0;
        bus.entry_pulse = 1'b0;
        bus.clear       = 1'b0;
        model_reset();
        #2;
        check("rst_gate_open",  int'(bus.gate_open),     0);
        check("rst_exit_pulse", int'(bus.exit_pulse),    0);
        check("rst_occupancy",  int'(bus.occupancy),     0);
        check("rst_lot_empty",  int'(bus.lot_empty),     1);
        check("rst_lot_full",   int'(bus.lot_full),      0);
        check("rst_err_ovf",    int'(bus.err_overflow),  0);
        check("rst_err_unf",    int'(bus.err_underflow), 0);
        check("rst_state",      int'(dbg_state),         0);
        do_reset();

        // Basic car with occupancy preloaded to 3.
        repeat (3) step(1'b0, 1'b1, 1'b0);
        repeat (DEBOUNCE - 1) step(1'b1, 1'b0, 1'b0);
        check("gate_before_qual", int'(bus.gate_open), 0);
        step(1'b1, 1'b0, 1'b0);
        check("gate_after_qual", int'(bus.gate_open), 1);
        repeat (DEBOUNCE - 1) step(1'b0, 1'b0, 1'b0);
        check("no_pulse_early", int'(bus.exit_pulse), 0);
        step(1'b0, 1'b0, 1'b0);
        check("pulse_on_depart", int'(bus.exit_pulse), 1);
        check("occ_3_to_2",      int'(bus.occupancy),  2);
        step(1'b0, 1'b0, 1'b0);
        check("pulse_one_cycle", int'(bus.exit_pulse), 0);

        // High glitch shorter than the debounce window.
        repeat (DEBOUNCE - 1) step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check("glitch_idle_state", int'(dbg_state), 0);
        check("glitch_gate_shut",  int'(bus.gate_open), 0);

        // Low glitch while the gate is up.
        repeat (DEBOUNCE) step(1'b1, 1'b0, 1'b0);
        repeat (DEBOUNCE - 1) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        check("low_glitch_gate_up", int'(bus.gate_open), 1);
        repeat (DEBOUNCE) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);

        // Fill the lot, coincident entry/departure at full, then overflow.
        step(1'b0, 1'b0, 1'b1);
        repeat (MAX_CARS) step(1'b0, 1'b1, 1'b0);
        check("full_occ",  int'(bus.occupancy), MAX_CARS);
        check("full_flag", int'(bus.lot_full),  1);
        car_pass(1'b1);
        check("coinc_full_occ", int'(bus.occupancy),    MAX_CARS);
        check("coinc_full_ovf", int'(bus.err_overflow), 0);
        step(1'b0, 1'b1, 1'b0);
        check("overflow_flag", int'(bus.err_overflow), 1);
        check("overflow_occ",  int'(bus.occupancy),    MAX_CARS);

        // Empty lot: coincident entry/departure, then a bare departure.
        step(1'b0, 1'b0, 1'b1);
        car_pass(1'b1);
        check("coinc_empty_occ", int'(bus.occupancy),     0);
        check("coinc_empty_unf", int'(bus.err_underflow), 0);
        car_pass(1'b0);
        check("underflow_pulse", int'(bus.exit_pulse),    1);
        check("underflow_flag",  int'(bus.err_underflow), 1);
        check("underflow_occ",   int'(bus.occupancy),     0);
        step(1'b0, 1'b0, 1'b1);
        check("clear_unf", int'(bus.err_underflow), 0);

        // Reset during DEPART after two low samples.
        repeat (5) step(1'b0, 1'b1, 1'b0);
        repeat (DEBOUNCE) step(1'b1, 1'b0, 1'b0);
        repeat (2) step(1'b0, 1'b0, 1'b0);
        check("pre_rst_state", int'(dbg_state), 3);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("async_rst_gate",  int'(bus.gate_open),  0);
        check("async_rst_pulse", int'(bus.exit_pulse), 0);
        check("async_rst_occ",   int'(bus.occupancy),  0);
        check("async_rst_empty", int'(bus.lot_empty),  1);
        @(negedge clk);
        rst = 1'b0;
        repeat (DEBOUNCE + 1) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        car_pass(1'b0);
        check("post_rst_pulse", int'(bus.exit_pulse), 1);
        check("post_rst_occ",   int'(bus.occupancy),  0);

        // Random traffic: held sensor levels of random length.
        for (int seg = 0; seg < 300; seg++) begin
            bit lvl;
            int len;
            lvl = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 2 * DEBOUNCE);
            for (int k = 0; k < len; k++)
                step(lvl, ($urandom_range(0, 3) == 0), ($urandom_range(0, 79) == 0));
        end
        repeat (2 * DEBOUNCE + 2) step(1'b0, 1'b0, 1'b0);

        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
